dsm_cic_decimator: RTL and testbench

Receive-side companion to the delta-sigma DAC modulator: accepts a 1-bit delta-sigma bitstream, for example from an external modulator or the DAC output looped back, and reconstructs signed multi-bit PCM samples. Implemented as an order-N CIC (sinc^N) decimator with power-of-two ratio, followed by a scale-and-saturate output stage. Sits between the comparator/bitstream input pin and the sample-domain datapath, and produces one sample strobe per R enabled input bits.

---
 rtl/dsm_pkg.sv | 35 +++
 rtl/dsm_cic_comb.sv | 38 +++
 rtl/dsm_cic_decimator.sv | 122 ++++++++++++
 tb/tb_dsm_cic_decimator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared delta-sigma definitions.
// Holds the bitstream polarity mapping shared by the DAC feedback path and the
// decimator, the CIC accumulator width rule, and a saturate-to-width helper.
package dsm_pkg;

  // Bit value on the wire and the level it represents.
  typedef enum logic {
    DSM_BIT_NEG = 1'b0,
    DSM_BIT_POS = 1'b1
  } dsm_bit_e;

  localparam int DSM_LEVEL_POS = 1;
  localparam int DSM_LEVEL_NEG = -1;

  // Register growth of an order-N CIC is N*log2(R) bits, plus sign and headroom.
  function automatic int cic_acc_width(input int order, input int decim_log2);
    return 2 + order * decim_log2;
  endfunction

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// Single CIC comb stage: o_data = i_data - (i_data captured at the previous
// enabled cycle). Modular WIDTH-bit arithmetic; integrator wrap cancels here.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : decimation event; captures i_data into the delay
//   i_data         : comb input (signed)
//   o_data         : combinational difference output (signed)
module dsm_cic_comb #(
  parameter int WIDTH = 20
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_data,
  output logic signed [WIDTH-1:0] o_data
);

  logic signed [WIDTH-1:0] delay_q;
  logic signed [WIDTH-1:0] delay_d;

  always_comb begin
    delay_d = delay_q;
    if (i_en) begin
      delay_d = i_data;
    end
  end

  assign o_data = i_data - delay_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      delay_q <= '0;
    end else begin
      delay_q <= delay_d;
    end
  end

endmodule

// File: rtl/dsm_cic_decimator.sv
// Order-N CIC (sinc^N) decimator for a 1-bit delta-sigma bitstream, followed
// by an arithmetic-shift scale and saturation to a DATA_WIDTH signed sample.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : input bit qualifier; all state advances only when high
//   i_bitstream    : modulator bit, 1 -> +1, 0 -> -1
//   o_data         : decimated, scaled, saturated sample (held between strobes)
//   o_valid        : one-cycle strobe marking a new o_data
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CIC_ORDER  = 3,
  parameter int DECIM_LOG2 = 6,
  parameter int ACC_WIDTH  = cic_acc_width(CIC_ORDER, DECIM_LOG2)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_bitstream,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid
);

  // Full-scale CIC output is R^N = 2^(N*log2 R); shift it down to the sample MSB.
  localparam int SHIFT    = CIC_ORDER * DECIM_LOG2 - (DATA_WIDTH - 1);
  localparam int SETTLE_W = $clog2(CIC_ORDER + 1);

  localparam logic [DECIM_LOG2-1:0] CNT_LAST    = '1;
  localparam logic [SETTLE_W-1:0]   SETTLE_DONE = SETTLE_W'(CIC_ORDER);

  logic signed [ACC_WIDTH-1:0]  x;
  logic signed [ACC_WIDTH-1:0]  integ_q [CIC_ORDER];
  logic signed [ACC_WIDTH-1:0]  integ_d [CIC_ORDER];
  logic        [DECIM_LOG2-1:0] cnt_q;
  logic        [DECIM_LOG2-1:0] cnt_d;
  logic        [SETTLE_W-1:0]   settle_q;
  logic        [SETTLE_W-1:0]   settle_d;
  logic signed [DATA_WIDTH-1:0] o_data_q;
  logic signed [DATA_WIDTH-1:0] o_data_d;
  logic                         o_valid_q;
  logic                         o_valid_d;
  logic                         dec_event;
  logic signed [ACC_WIDTH-1:0]  comb_chain [CIC_ORDER+1];
  logic signed [ACC_WIDTH-1:0]  scaled;

  assign x = (dsm_bit_e'(i_bitstream) == DSM_BIT_POS) ? ACC_WIDTH'(DSM_LEVEL_POS)
                                                       : ACC_WIDTH'(DSM_LEVEL_NEG);

  assign dec_event = i_en && (cnt_q == CNT_LAST);

  // Comb chain runs at the decimated rate, fed by the last integrator's register.
  assign comb_chain[0] = integ_q[CIC_ORDER-1];

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
    dsm_cic_comb #(
      .WIDTH (ACC_WIDTH)
    ) u_comb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (dec_event),
      .i_data  (comb_chain[k]),
      .o_data  (comb_chain[k+1])
    );
  end

  assign scaled = comb_chain[CIC_ORDER] >>> SHIFT;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    integ_d   = integ_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;

    if (i_en) begin
      // Each stage reads the previous stage's registered value: one cycle of
      // delay per stage. Wrap-around is intentional; the combs undo it.
      integ_d[0] = integ_q[0] + x;
      for (int k = 1; k < CIC_ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      cnt_d = cnt_q + 1'b1;
    end

    // The first CIC_ORDER events only fill the comb delays.
    if (dec_event) begin
      if (settle_q == SETTLE_DONE) begin
        o_valid_d = 1'b1;
        o_data_d  = DATA_WIDTH'(sat_to_width(64'(scaled), DATA_WIDTH));
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ_q[k] <= '0;
      end
      cnt_q     <= '0;
      settle_q  <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      integ_q   <= integ_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Self-checking bench for dsm_cic_decimator. The reference model treats the
// decimator as an FIR: the N-fold convolution of a length-R boxcar applied to
// the +/-1 input history, delayed by one sample per integrator stage, sampled
// every R enabled bits once N settling events have passed.
module tb_dsm_cic_decimator;

  localparam int DW    = 16;
  localparam int N     = 3;
  localparam int RLOG  = 6;
  localparam int R     = 1 << RLOG;
  localparam int SHIFT = N * RLOG - (DW - 1);
  localparam int HLEN  = N * (R - 1) + 1;
  localparam int SMAX  = (1 << (DW - 1)) - 1;
  localparam int SMIN  = -(1 << (DW - 1));

  logic                 clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_en;
  logic                 i_bitstream;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;

  dsm_cic_decimator #(
    .DATA_WIDTH (DW),
    .CIC_ORDER  (N),
    .DECIM_LOG2 (RLOG)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_bitstream (i_bitstream),
    .o_data      (o_data),
    .o_valid     (o_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int h [HLEN];
  int xs [$];
  int n_events;
  int exp_valid;
  int exp_data;

  // Per-test observation controls
  int cycle       = 0;
  int strobes     = 0;
  int last_strobe = -1;
  int gap_exp     = 0;
  int const_on    = 0;
  int const_val   = 0;
  int tol         = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic signed [31:0] obs,
                           input int exp, input int t);
    checks++;
    assert (!$isunknown(obs) && (obs - exp <= t) && (exp - obs <= t)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, t);
    end
  endtask

  function automatic int model_sample();
    longint acc;
    int     n;
    int     idx;
    acc = 0;
    n   = xs.size() - 1;
    for (int j = 0; j < HLEN; j++) begin
      idx = n - N - j;
      if (idx >= 0) acc += longint'(h[j]) * longint'(xs[idx]);
    end
    acc = acc >>> SHIFT;
    if (acc > SMAX) return SMAX;
    if (acc < SMIN) return SMIN;
    return int'(acc);
  endfunction

  // Apply one cycle of inputs, advance the model, and compare outputs.
  task automatic step(input logic rst_n, input logic en, input logic b);
    i_rst_n     = rst_n;
    i_en        = en;
    i_bitstream = b;
    @(posedge clk);
    #1;
    cycle++;
    exp_valid = 0;
    if (!rst_n) begin
      xs.delete();
      n_events = 0;
      exp_data = 0;
    end else if (en) begin
      xs.push_back(b ? 1 : -1);
      if (xs.size() % R == 0) begin
        n_events++;
        if (n_events > N) begin
          exp_valid = 1;
          exp_data  = model_sample();
        end
      end
    end
    check("o_valid", o_valid, exp_valid);
    if (tol == 0) check("o_data", o_data, exp_data);
    else          check_tol("o_data_rand", o_data, exp_data, tol);
    if (o_valid === 1'b1) begin
      strobes++;
      if (const_on != 0) check("strobe_value", o_data, const_val);
      if (gap_exp > 0 && last_strobe >= 0) check("strobe_gap", cycle - last_strobe, gap_exp);
      last_strobe = cycle;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    strobes     = 0;
    last_strobe = -1;
  endtask

  initial begin
    int first_c;

    for (int i = 0; i < HLEN; i++) h[i] = (i < R) ? 1 : 0;
    for (int s = 1; s < N; s++) begin
      int tmp [HLEN];
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) tmp[i] += h[i-j];
      end
      h = tmp;
    end
    n_events  = 0;
    exp_valid = 0;
    exp_data  = 0;

    // Reset state
    do_reset();
    check("reset_data", o_data, 0);
    check("reset_valid", o_valid, 0);

    // Constant ones: 8 events, first 3 settle -> 5 saturated strobes
    const_on = 1; const_val = SMAX; gap_exp = R;
    for (int c = 0; c < 8 * R; c++) step(1'b1, 1'b1, 1'b1);
    check("ones_strobes", strobes, 5);

    // Constant zeros
    do_reset();
    const_val = SMIN;
    for (int c = 0; c < 8 * R; c++) step(1'b1, 1'b1, 1'b0);
    check("zeros_strobes", strobes, 5);

    // 1,0 repeating -> 0
    do_reset();
    const_val = 0;
    for (int c = 0; c < 8 * R; c++) step(1'b1, 1'b1, (c % 2) == 0);
    check("p10_strobes", strobes, 5);

    // 1,1,1,0 repeating -> half scale
    do_reset();
    const_val = 1 << (DW - 2);
    for (int c = 0; c < 8 * R; c++) step(1'b1, 1'b1, (c % 4) != 3);
    check("p1110_strobes", strobes, 5);

    // i_en toggling with constant ones: strobes every 2R clocks
    do_reset();
    const_val = SMAX; gap_exp = 2 * R;
    for (int c = 0; c < 16 * R; c++) step(1'b1, (c % 2) == 0, 1'b1);
    check("en_toggle_strobes", strobes, 5);

    // Reset 20 cycles into a period, after two strobes
    do_reset();
    gap_exp = R;
    for (int c = 0; c < 5 * R + 20; c++) step(1'b1, 1'b1, 1'b1);
    check("pre_midreset_strobes", strobes, 2);
    step(1'b0, 1'b1, 1'b1);
    check("midreset_data", o_data, 0);
    check("midreset_valid", o_valid, 0);
    strobes = 0; last_strobe = -1; first_c = -1;
    for (int c = 1; c <= 4 * R + 8; c++) begin
      step(1'b1, 1'b1, 1'b1);
      if (o_valid === 1'b1 && first_c < 0) first_c = c;
    end
    check("post_reset_first_strobe", first_c, 4 * R);
    check("post_reset_strobes", strobes, 1);

    // Reset coinciding with a decimation event wins
    do_reset();
    for (int c = 0; c < 5 * R - 1; c++) step(1'b1, 1'b1, 1'b1);
    check("pre_coincide_strobes", strobes, 1);
    step(1'b0, 1'b1, 1'b1);
    check("coincide_valid", o_valid, 0);
    check("coincide_data", o_data, 0);

    // Wrap stress: random bitstream, 25% ones, integrators wrap freely
    do_reset();
    const_on = 0; tol = 1; gap_exp = R;
    for (int c = 0; c < 20000; c++) step(1'b1, 1'b1, $urandom_range(3) == 0);
    check("rand_strobes", strobes, 20000 / R - N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
